// File: rtl/ahb_resp_mux.sv
// AHB data-phase response multiplexer with an optional built-in default slave.
// Define AHB_RESP_MUX_DEF_SLV_EN to build the default slave, which answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR.
`default_nettype none

module ahb_resp_mux #(
    parameter int slv_c = 4
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic [slv_c-1:0]        hsel,
    input  logic [1:0]              htrans,
    input  logic [slv_c-1:0][31:0]  hrdata_s,
    input  logic [slv_c-1:0]        hresp_s,
    input  logic [slv_c-1:0]        hreadyout_s,
    output logic [31:0]             hrdata,
    output logic                    hresp,
    output logic                    hready
);

    logic [slv_c-1:0]       sel_dp_reg;
    logic [slv_c-1:0]       sel_dp_next;
    logic [slv_c-1:0]       hsel_low;
    logic [slv_c-1:0][31:0] rdata_masked;
    logic [31:0]            rdata_or;
    logic                   slv_active;
    logic                   slv_resp;
    logic                   slv_ready;
    logic                   ds_resp;
    logic                   ds_ready;

    // Isolate the lowest set bit so a malformed multi-bit select still picks exactly one slave.
    assign hsel_low = hsel & (~hsel + slv_c'(1));

    always_comb begin
        sel_dp_next = sel_dp_reg;
        if (hready) begin
            sel_dp_next = hsel_low;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sel_dp_reg <= '0;
        end else begin
            sel_dp_reg <= sel_dp_next;
        end
    end

    generate
        for (genvar gi = 0; gi < slv_c; gi++) begin : g_rdata_mask
            assign rdata_masked[gi] = sel_dp_reg[gi] ? hrdata_s[gi] : 32'h0;
        end
    endgenerate

    always_comb begin
        rdata_or = 32'h0;
        for (int i = 0; i < slv_c; i++) begin
            rdata_or = rdata_or | rdata_masked[i];
        end
    end

    assign slv_active = |sel_dp_reg;
    assign slv_resp   = |(sel_dp_reg & hresp_s);
    assign slv_ready  = |(sel_dp_reg & hreadyout_s);

`ifdef AHB_RESP_MUX_DEF_SLV_EN
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    ds_state_t ds_state_reg;
    ds_state_t ds_state_next;
    logic      def_dp_reg;
    logic      def_dp_next;

    always_comb begin
        def_dp_next = def_dp_reg;
        if (hready) begin
            def_dp_next = (hsel == '0) && htrans[1];
        end
    end

    // def_dp_next is the flag about to be registered, so the ERROR starts in the very next data phase.
    always_comb begin
        ds_state_next = ds_state_reg;
        case (ds_state_reg)
            DS_IDLE: if (def_dp_next) ds_state_next = DS_ERR1;
            DS_ERR1: ds_state_next = DS_ERR2;
            DS_ERR2: ds_state_next = def_dp_next ? DS_ERR1 : DS_IDLE;
            default: ds_state_next = DS_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ds_state_reg <= DS_IDLE;
            def_dp_reg   <= 1'b0;
        end else begin
            ds_state_reg <= ds_state_next;
            def_dp_reg   <= def_dp_next;
        end
    end

    // def_dp is high exactly while the FSM sits in DS_ERR1 or DS_ERR2.
    assign ds_resp  = def_dp_reg;
    assign ds_ready = (ds_state_reg != DS_ERR1);
`else
    logic unused_htrans;

    assign unused_htrans = ^htrans;
    assign ds_resp       = 1'b0;
    assign ds_ready      = 1'b1;
`endif

    assign hrdata = rdata_or;
    assign hresp  = slv_active ? slv_resp  : ds_resp;
    assign hready = slv_active ? slv_ready : ds_ready;

endmodule

`default_nettype wire

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: a driver pushes expected responses from a transfer-level model,
// a monitor pops and compares them on the falling edge.
module tb_ahb_resp_mux;

`ifdef AHB_RESP_MUX_DEF_SLV_EN
    localparam bit DEF_EN = 1'b1;
`else
    localparam bit DEF_EN = 1'b0;
`endif

    logic             hclk;
    logic             hresetn;
    logic [3:0]       hsel;
    logic [1:0]       htrans;
    logic [3:0][31:0] hrdata_s;
    logic [3:0]       hresp_s;
    logic [3:0]       hreadyout_s;
    logic [31:0]      hrdata;
    logic             hresp;
    logic             hready;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        logic        ready;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn_id   = 0;

    // Transfer-level model: who owns the current data phase, and how far into an ERROR we are.
    int   owner     = -1;
    int   err_phase = 0;

    ahb_resp_mux #(.slv_c(4)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hsel        (hsel),
        .htrans      (htrans),
        .hrdata_s    (hrdata_s),
        .hresp_s     (hresp_s),
        .hreadyout_s (hreadyout_s),
        .hrdata      (hrdata),
        .hresp       (hresp),
        .hready      (hready)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.id = 0;
        if (owner >= 0) begin
            e.rdata = hrdata_s[owner];
            e.resp  = hresp_s[owner];
            e.ready = hreadyout_s[owner];
        end else begin
            e.rdata = 32'h0;
            e.resp  = (err_phase != 0);
            e.ready = (err_phase != 1);
        end
        return e;
    endfunction

    function automatic void model_step(logic [3:0] s, logic [1:0] t, logic rdy);
        if (rdy) begin
            owner = -1;
            for (int i = 3; i >= 0; i--) begin
                if (s[i]) owner = i;
            end
            err_phase = (owner < 0 && DEF_EN && t >= 2) ? 1 : 0;
        end else if (err_phase == 1) begin
            err_phase = 2;
        end
    endfunction

    task automatic drive(input logic [3:0] s, input logic [1:0] t, input logic [3:0] rdy, input logic [3:0] rsp);
        exp_t e;
        hsel        = s;
        htrans      = t;
        hreadyout_s = rdy;
        hresp_s     = rsp;
        e    = model_out();
        e.id = txn_id;
        txn_id++;
        sb.push_back(e);
        @(posedge hclk);
        model_step(s, t, e.ready);
        #1;
    endtask

    // Monitor: one scoreboard entry per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("txn%0d_hrdata", e.id), hrdata, e.rdata);
                chk($sformatf("txn%0d_hresp", e.id), {31'h0, hresp}, {31'h0, e.resp});
                chk($sformatf("txn%0d_hready", e.id), {31'h0, hready}, {31'h0, e.ready});
                $display("txn %0d hrdata=%h hresp=%0b hready=%0b", e.id, hrdata, hresp, hready);
            end
        end
    end

    initial begin
        logic [3:0] s;
        logic [3:0] rdy;
        hresetn     = 1'b0;
        hsel        = 4'h0;
        htrans      = 2'd0;
        hrdata_s    = '0;
        hresp_s     = 4'h0;
        hreadyout_s = 4'hF;
        repeat (2) @(posedge hclk);
        #1;
        chk("reset_hrdata", hrdata, 32'h0);
        chk("reset_hresp", {31'h0, hresp}, 32'h0);
        chk("reset_hready", {31'h0, hready}, 32'h1);
        hresetn = 1'b1;

        // Basic read from slave 1.
        hrdata_s[0] = 32'h0000_AAAA;
        hrdata_s[1] = 32'hDEAD_BEEF;
        hrdata_s[2] = 32'h1234_5678;
        hrdata_s[3] = 32'hCAFE_F00D;
        drive(4'b0010, 2'd2, 4'hF, 4'h0);
        drive(4'b0000, 2'd0, 4'hF, 4'h0);

        // Slave 2 stalls three cycles while the next address phase targets slave 0.
        drive(4'b0100, 2'd2, 4'hF, 4'h0);
        repeat (3) drive(4'b0001, 2'd2, 4'b1011, 4'h0);
        drive(4'b0001, 2'd2, 4'hF, 4'h0);
        drive(4'b0000, 2'd0, 4'hF, 4'h0);

        // Single unmapped NONSEQ, then back-to-back unmapped transfers.
        drive(4'b0000, 2'd2, 4'hF, 4'h0);
        repeat (3) drive(4'b0000, 2'd0, 4'hF, 4'h0);
        drive(4'b0000, 2'd2, 4'hF, 4'h0);
        drive(4'b0000, 2'd2, 4'hF, 4'h0);
        drive(4'b0000, 2'd2, 4'hF, 4'h0);
        repeat (3) drive(4'b0000, 2'd0, 4'hF, 4'h0);

        // Multi-bit select: lowest index wins; then IDLE to nowhere.
        drive(4'b0110, 2'd2, 4'hF, 4'h0);
        drive(4'b0000, 2'd0, 4'hF, 4'h0);
        drive(4'b0000, 2'd0, 4'hF, 4'h0);

        // Asynchronous reset asserted mid-cycle during the first ERROR cycle.
        drive(4'b0000, 2'd2, 4'hF, 4'h0);
        #2;
        hresetn = 1'b0;
        #1;
        chk("async_rst_hrdata", hrdata, 32'h0);
        chk("async_rst_hresp", {31'h0, hresp}, 32'h0);
        chk("async_rst_hready", {31'h0, hready}, 32'h1);
        owner     = -1;
        err_phase = 0;
        hsel      = 4'h0;
        htrans    = 2'd0;
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        drive(4'b0000, 2'd0, 4'hF, 4'h0);
        drive(4'b0000, 2'd0, 4'hF, 4'h0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      s = 4'h0;
            else if (r < 8) s = 4'b0001 << $urandom_range(0, 3);
            else            s = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                rdy[i]      = ($urandom_range(0, 3) != 0);
                hrdata_s[i] = $urandom;
            end
            drive(s, 2'($urandom_range(0, 3)), rdy, 4'($urandom_range(0, 15)));
        end

        @(negedge hclk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
